// File: rtl/alu_pkg.sv
// Purpose: shared widths, ALU opcodes and flag bit positions for the datapath core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam int FLAG_W = 8;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_ADC = 4'h2,
        ALU_SBB = 4'h3,
        ALU_AND = 4'h4,
        ALU_OR  = 4'h5,
        ALU_XOR = 4'h6,
        ALU_NOT = 4'h7,
        ALU_SHL = 4'h8,
        ALU_SHR = 4'h9,
        ALU_ROL = 4'hA,
        ALU_ROR = 4'hB,
        ALU_CMP = 4'hC,
        ALU_MOV = 4'hD,
        ALU_MUL = 4'hE,
        ALU_DIV = 4'hF
    } alu_op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_unit.sv
// Purpose: combinational 32-bit ALU producing result and {passthru[7:4], V, N, Z, C}.
// Latency: zero cycles, outputs follow inputs combinationally.
// Backpressure: none; no handshake, caller samples whenever it likes.
// Ports: a/b operands, op select, flags_in (bit C = carry/borrow in, [7:4] passed through),
//        result and flags_out.
module alu_unit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags_out
);

    logic [DATA_W:0]     wide;   // 33-bit scratch: carry/borrow or shifted-out bit lands in the extra bit
    logic [2*DATA_W-1:0] dbl;    // doubled operand for rotates, full product for MUL
    logic [4:0]          amt;
    logic                cin;
    logic                c_flag;
    logic                v_flag;

    // flags_in[3:1] are outputs of the previous op and carry no meaning here
    logic unused_flags;
    assign unused_flags = ^flags_in[3:1];

    assign amt = b[4:0];
    assign cin = flags_in[FLAG_C];

    always_comb begin
        result = '0;
        wide   = '0;
        dbl    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD, ALU_ADC: begin
                wide   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (op == ALU_ADC) & cin};
                result = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                v_flag = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB, ALU_CMP, ALU_SBB: begin
                // Bit 32 of the zero-extended difference wraps to 1 exactly when a borrow occurs
                wide   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, (op == ALU_SBB) & cin};
                result = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                v_flag = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                // Last bit out ends up in wide[32]; zero shift leaves it 0
                wide   = {1'b0, a} << amt;
                result = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
            end
            ALU_SHR: begin
                wide   = {a, 1'b0} >> amt;
                result = wide[DATA_W:1];
                c_flag = wide[0];
            end
            ALU_ROL: begin
                dbl    = {a, a} << amt;
                result = dbl[2*DATA_W-1:DATA_W];
            end
            ALU_ROR: begin
                dbl    = {a, a} >> amt;
                result = dbl[DATA_W-1:0];
            end
            ALU_MOV: result = b;
            ALU_MUL: begin
                dbl    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                result = dbl[DATA_W-1:0];
                c_flag = |dbl[2*DATA_W-1:DATA_W];
                v_flag = |dbl[2*DATA_W-1:DATA_W];
            end
            ALU_DIV: begin
                if (b == '0) begin
                    result = '1;
                    v_flag = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags_out         = '0;
        flags_out[7:4]    = flags_in[7:4];
        flags_out[FLAG_C] = c_flag;
        flags_out[FLAG_Z] = (result == '0);
        flags_out[FLAG_N] = result[DATA_W-1];
        flags_out[FLAG_V] = v_flag;
    end

endmodule

// File: rtl/reg_bank.sv
// Purpose: NREGS x DATA_W register file, two async read ports, one sync write port, no bypass.
// Latency: reads combinational; write visible after the rising edge.
// Backpressure: none; write accepted every cycle write_en is high and rst_n is released.
// Ports: clk, rst_n (async active-low clear), addr_a/data_a, addr_b/data_b, addr_w/data_w/write_en.
module reg_bank
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] addr_a,
    output logic [DATA_W-1:0] data_a,
    input  logic [REG_AW-1:0] addr_b,
    output logic [DATA_W-1:0] data_b,
    input  logic [REG_AW-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              write_en
);

    logic [DATA_W-1:0] regs [NREGS];

    // Reset dominates: a write presented while rst_n is low is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[addr_w] <= data_w;
        end
    end

    // Reading the address being written returns the pre-edge contents
    assign data_a = regs[addr_a];
    assign data_b = regs[addr_b];

endmodule

// File: rtl/alu_regfile.sv
// Purpose: datapath core wrapper: combinational ALU alongside an independent 32x32 register file.
// Latency: ALU and reads zero cycles; register write takes effect on the rising edge of clk.
// Backpressure: none; the control FSM owns all sequencing.
// Ports: alu_a/alu_b/alu_op/flags_in -> alu_result/flags_out;
//        addr_a->data_a, addr_b->data_b, addr_w/data_w/write_en on clk, rst_n async clear.
module alu_regfile
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   alu_a,
    input  logic [DATA_W-1:0]   alu_b,
    input  logic [3:0]          alu_op,
    input  logic [FLAG_W-1:0]   flags_in,
    output logic [DATA_W-1:0]   alu_result,
    output logic [FLAG_W-1:0]   flags_out,
    input  logic [REG_AW-1:0]   addr_a,
    output logic [DATA_W-1:0]   data_a,
    input  logic [REG_AW-1:0]   addr_b,
    output logic [DATA_W-1:0]   data_b,
    input  logic [REG_AW-1:0]   addr_w,
    input  logic [DATA_W-1:0]   data_w,
    input  logic                write_en
);

    alu_unit u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .op        (alu_op),
        .flags_in  (flags_in),
        .result    (alu_result),
        .flags_out (flags_out)
    );

    reg_bank u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_a   (addr_a),
        .data_a   (data_a),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .write_en (write_en)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Purpose: directed-vector bench for alu_regfile with hand-computed expectations.
// Latency: ALU checked 1 time unit after inputs change; register writes checked after the edge.
// Backpressure: n/a.
module tb_alu_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  flags_in;
    logic [31:0] alu_result;
    logic [7:0]  flags_out;
    logic [4:0]  addr_a;
    logic [31:0] data_a;
    logic [4:0]  addr_b;
    logic [31:0] data_b;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        write_en;

    int n_vec;
    int n_miss;

    alu_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .flags_in   (flags_in),
        .alu_result (alu_result),
        .flags_out  (flags_out),
        .addr_a     (addr_a),
        .data_a     (data_a),
        .addr_b     (addr_b),
        .data_b     (data_b),
        .addr_w     (addr_w),
        .data_w     (data_w),
        .write_en   (write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  fin;
        logic [31:0] res;
        logic [7:0]  fout;
    } alu_vec_t;

    // flags_out layout: {fin[7:4], V, N, Z, C}
    alu_vec_t vecs[$] = '{
        '{"add_ovf",   4'h0, 32'h7FFFFFFF, 32'h00000001, 8'h00, 32'h80000000, 8'h0C},
        '{"add_carry", 4'h0, 32'hFFFFFFFF, 32'h00000001, 8'h00, 32'h00000000, 8'h03},
        '{"sub_borrow",4'h1, 32'h00000005, 32'h00000007, 8'h00, 32'hFFFFFFFE, 8'h05},
        '{"sub_ovf",   4'h1, 32'h80000000, 32'h00000001, 8'h00, 32'h7FFFFFFF, 8'h08},
        '{"cmp_eq",    4'hC, 32'h00000009, 32'h00000009, 8'h00, 32'h00000000, 8'h02},
        '{"adc_cin",   4'h2, 32'h00000001, 32'h00000001, 8'h01, 32'h00000003, 8'h00},
        '{"sbb_cin",   4'h3, 32'h00000005, 32'h00000005, 8'h01, 32'hFFFFFFFF, 8'h05},
        '{"and_pass",  4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 8'hA0, 32'h00F000F0, 8'hA0},
        '{"or_pass",   4'h5, 32'h0000000F, 32'h000000F0, 8'h5F, 32'h000000FF, 8'h50},
        '{"xor_zero",  4'h6, 32'h12345678, 32'h12345678, 8'h00, 32'h00000000, 8'h02},
        '{"not_zero",  4'h7, 32'h00000000, 32'h55555555, 8'h00, 32'hFFFFFFFF, 8'h04},
        '{"shl_c",     4'h8, 32'h80000001, 32'h00000001, 8'h00, 32'h00000002, 8'h01},
        '{"shl_zero",  4'h8, 32'h80000000, 32'h00000000, 8'h01, 32'h80000000, 8'h04},
        '{"shr_c",     4'h9, 32'h00000003, 32'h00000001, 8'h00, 32'h00000001, 8'h01},
        '{"shr_31",    4'h9, 32'h80000000, 32'h0000001F, 8'h00, 32'h00000001, 8'h00},
        '{"rol_4",     4'hA, 32'h80000001, 32'h00000004, 8'h00, 32'h00000018, 8'h00},
        '{"ror_1",     4'hB, 32'h00000001, 32'h00000001, 8'h00, 32'h80000000, 8'h04},
        '{"mov",       4'hD, 32'hFFFFFFFF, 32'h12345678, 8'h00, 32'h12345678, 8'h00},
        '{"mul_hi",    4'hE, 32'h00010000, 32'h00010000, 8'h00, 32'h00000000, 8'h0B},
        '{"mul_small", 4'hE, 32'h00000006, 32'h00000007, 8'h00, 32'h0000002A, 8'h00},
        '{"div",       4'hF, 32'h00000064, 32'h00000007, 8'h00, 32'h0000000E, 8'h00},
        '{"div_zero",  4'hF, 32'h00000005, 32'h00000000, 8'h00, 32'hFFFFFFFF, 8'h0C}
    };

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = '0;
        flags_in = '0;
        addr_a   = 5'd0;
        addr_b   = 5'd31;
        addr_w   = '0;
        data_w   = '0;
        write_en = 1'b0;

        // Reset state of the register file
        #2;
        chk("rst_data_a", data_a, 32'h0);
        chk("rst_data_b", data_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU vectors: purely combinational, no clock involvement
        foreach (vecs[i]) begin
            alu_op   = vecs[i].op;
            alu_a    = vecs[i].a;
            alu_b    = vecs[i].b;
            flags_in = vecs[i].fin;
            #1;
            chk({vecs[i].tag, "_res"}, alu_result, vecs[i].res);
            chk({vecs[i].tag, "_flg"}, {24'h0, flags_out}, {24'h0, vecs[i].fout});
        end

        // Write R5; before the edge both ports still show the old value
        @(negedge clk);
        addr_w   = 5'd5;
        data_w   = 32'hDEADBEEF;
        write_en = 1'b1;
        addr_a   = 5'd5;
        addr_b   = 5'd5;
        #1;
        chk("wr_same_cycle_a", data_a, 32'h0);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        chk("wr_r5_a", data_a, 32'hDEADBEEF);
        chk("wr_r5_b", data_b, 32'hDEADBEEF);

        // write_en low leaves contents alone
        @(negedge clk);
        data_w = 32'h0BADF00D;
        @(posedge clk);
        #1;
        chk("no_we_r5", data_a, 32'hDEADBEEF);

        // R0 is an ordinary register
        @(negedge clk);
        addr_w   = 5'd0;
        data_w   = 32'h00001234;
        write_en = 1'b1;
        addr_a   = 5'd0;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        chk("wr_r0", data_a, 32'h00001234);

        // Fill R1..R31 with nonzero patterns
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            addr_w   = 5'(r);
            data_w   = 32'h80000000 | (32'(r) * 32'h01010101);
            write_en = 1'b1;
        end
        @(negedge clk);
        write_en = 1'b0;
        addr_a   = 5'd31;
        addr_b   = 5'd17;
        #1;
        chk("fill_r31", data_a, 32'h9F1F1F1F);
        chk("fill_r17", data_b, 32'h91111111);

        // Async reset between edges, with a write pending
        @(posedge clk);
        #2;
        addr_w   = 5'd3;
        data_w   = 32'hFFFF0000;
        write_en = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("arst_r31_now", data_a, 32'h0);
        chk("arst_r17_now", data_b, 32'h0);
        for (int r = 0; r < 32; r++) begin
            addr_a = 5'(r);
            addr_b = 5'(31 - r);
            #1;
            chk($sformatf("arst_a_r%0d", r), data_a, 32'h0);
            chk($sformatf("arst_b_r%0d", 31 - r), data_b, 32'h0);
        end
        // Let at least one rising edge pass with the write still requested
        @(posedge clk);
        #1;
        addr_a = 5'd3;
        #1;
        chk("wr_during_rst", data_a, 32'h0);
        @(negedge clk);
        write_en = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("r3_after_rst", data_a, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Datapath core of the 32-bit CPU: a purely combinational 32-bit ALU plus a 32x32 register file.
- The register file has two asynchronous read ports and one synchronous write port.
- The CPU control FSM drives operands, opcode, flags and register addresses. It latches result/flags and writes back through the write port.

Parameters:
- DATA_W, 32, datapath width.
- NREGS, 32, number of registers; address width = log2(NREGS) = 5.

Ports:
- clk  in  1  clock; register file writes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low; clock clk.
- alu_a  in  32  operand A.
- alu_b  in  32  operand B.
- alu_op  in  4  operation select.
- flags_in  in  8  current flags; [0]=C used as carry/borrow in; [7:4] passed through.
- alu_result  out  32  combinational result.
- flags_out  out  8  {flags_in[7:4], V, N, Z, C}.
- addr_a  in  5  read port A address.
- data_a  out  32  read port A data.
- addr_b  in  5  read port B address.
- data_b  out  32  read port B data.
- addr_w  in  5  write address.
- data_w  in  32  write data.
- write_en  in  1  write strobe.

Behaviour:
- ALU is fully combinational, zero latency.
- For every op: Z = (result==0); N = result[31]. C and V per op below.
- 0 ADD: a+b. C = carry out. V = signed overflow (same-sign operands, different-sign result).
- 1 SUB: a-b. C = borrow (a<b unsigned). V = signed overflow (operand signs differ, result sign != a sign).
- 2 ADC: a+b+flags_in[0]. C and V as ADD.
- 3 SBB: a-b-flags_in[0]. C = borrow; V as SUB.
- 4 AND, 5 OR, 6 XOR: bitwise. C=0, V=0.
- 7 NOT: ~a, b ignored. C=0, V=0.
- 8 SHL: a << b[4:0]. C = last bit shifted out; C=0 when amount is 0. V=0.
- 9 SHR: logical a >> b[4:0]. C = last bit shifted out; C=0 when amount is 0. V=0.
- A ROL: rotate left by b[4:0]. C=0, V=0.
- B ROR: rotate right by b[4:0]. C=0, V=0.
- C CMP: result and flags identical to SUB. The caller decides whether to write back.
- D MOV: result = b. C=0, V=0.
- E MUL: unsigned, result = low 32 bits. C=V=1 iff the upper 32 bits of the 64-bit product are nonzero.
- F DIV: unsigned quotient.
  - b==0: result=0xFFFFFFFF, V=1, C=0, Z=0, N=1.
  - Otherwise C=0, V=0.
- flags_out[7:4] always equals flags_in[7:4].
- Register file storage: NREGS x DATA_W. All registers, including R0, are general and writable; none is hardwired.
- Reads: data_a = reg[addr_a], data_b = reg[addr_b], combinational.
- Write: on posedge clk with write_en=1, reg[addr_w] <= data_w.
- Read of addr_w in the write cycle returns the OLD value (no bypass). The new value is visible after the edge.
- Reset: rst_n low clears all registers to 0 immediately, independent of clk. Write is suppressed while rst_n is low.
- Reset asserted mid-operation overrides any pending write.
- Outputs after reset: data_a = data_b = 0. ALU outputs depend only on their inputs.
- Two reads of the same address return identical data.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op codes ALU_ADD=0 … ALU_DIV=F.
  - Flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
  - DATA_W and NREGS.
- Sub-modules: alu_unit (combinational ALU) and reg_bank (register file). alu_regfile only instantiates and wires them; the two have no internal connection.

Test Plan:
- ADD 0x7FFFFFFF+1 -> result 0x80000000, N=1, V=1, C=0, Z=0. ADD 0xFFFFFFFF+1 -> 0, Z=1, C=1, V=0.
- SUB 5-7 -> 0xFFFFFFFE, C=1, N=1. CMP 9,9 -> result 0, Z=1, C=0. ADC 1+1 with flags_in=0x01 -> 3.
- SHL 0x80000001 by 1 -> 0x00000002, C=1. SHR 0x3 by 1 -> 0x1, C=1. NOT 0 -> 0xFFFFFFFF, N=1. flags_in=0xA0 -> flags_out[7:4]=0xA.
- MUL 0x10000*0x10000 -> 0, Z=1, C=V=1. MUL 6*7 -> 42, C=V=0. DIV 100/7 -> 14. DIV by 0 -> 0xFFFFFFFF, V=1.
- Write 0xDEADBEEF to R5, read both ports at 5 next cycle -> both 0xDEADBEEF. Same-cycle read during write -> old value 0. write_en=0 -> no change. R0 write 0x1234 -> reads 0x1234.
- Load R1..R31 with nonzero values, assert rst_n low asynchronously between edges -> all reads 0 immediately. Write attempted during reset is ignored.
